imem_load_arbiter: RTL and testbench
====================================

// Module: imem_load_arbiter
// PURPOSE
//  Sole owner of the 256x16 instruction memory port (rw_enable: 1=read, 0=write; 1-cycle registered read).
//  Arbitrates between CPU instruction fetch and a byte-serial program loader (UART/boot ROM side).
//  The loader packs byte pairs into 16-bit words and writes them at auto-incrementing addresses from 0.
//  Fetch is stalled for the whole load; there is never a write and a read in the same cycle.
// PARAMETERS
//  ADDR_W      8   memory word-address width; depth = 2**ADDR_W
//  LO_FIRST    1   1: first byte of a pair -> data[7:0]; 0: first byte -> data[15:8]
// PORTS
//  clk          in   1         system clock, rising edge
//  rst          in   1         synchronous reset, active-high
//  fetch_req    in   1         CPU requests the word at fetch_addr this cycle
//  fetch_addr   in   ADDR_W    fetch word address
//  fetch_stall  out  1         1 = fetch_req is ignored this cycle (load in progress)
//  fetch_valid  out  1         fetch_data holds the word for the request accepted last cycle
//  fetch_data   out  16        = mem_rdata (combinational pass-through)
//  ld_start     in   1         pulse: begin a load of ld_words words at address 0
//  ld_words     in   ADDR_W+1  word count, sampled on ld_start; 0 means 2**ADDR_W
//  ld_abort     in   1         abandon the load; any partial word is discarded
//  ld_valid     in   1         ld_byte is valid (transfer when ld_valid && ld_ready)
//  ld_byte      in   8         loader byte
//  ld_ready     out  1         block accepts a loader byte this cycle
//  ld_busy      out  1         1 whenever state != RUN
//  ld_done      out  1         one-cycle pulse after the final word is written
//  mem_rw_en    out  1         memory rw_enable: 1=read, 0=write
//  mem_addr     out  ADDR_W    memory address
//  mem_wdata    out  16        memory write data
//  mem_rdata    in   16        memory read data
// BEHAVIOUR
//  Reset: state=RUN, wr_addr=0, word_cnt=0, byte regs=0, fetch_valid=0, ld_done=0, mem_rw_en=1.
//   The reset cycle never produces a write, including a reset asserted mid-load or during WR.
//  States:
//   RUN  -> LO on ld_start (latch ld_words; wr_addr, word_cnt <- 0). Fetch is served; ld_ready=0.
//   LO   -> HI on byte transfer (capture first byte); -> RUN on ld_abort.
//   HI   -> WR on byte transfer (capture second byte); -> RUN on ld_abort.
//   WR   -> mem_rw_en=0, mem_addr=wr_addr, mem_wdata=packed word; wr_addr++, word_cnt++.
//           -> DONE if word_cnt == len-1, else -> LO. ld_abort is ignored in WR (write completes).
//   DONE -> ld_done=1 for this cycle only -> RUN.
//  ld_ready=1 only in LO/HI. ld_abort takes priority over a same-cycle byte transfer (byte dropped).
//  ld_start outside RUN is ignored. ld_abort in RUN/DONE is ignored; an abort gives no ld_done.
//  Fetch: fetch_stall = (state != RUN). In RUN: mem_rw_en=1, mem_addr=fetch_addr.
//   fetch_valid <= fetch_req && state==RUN && !rst; fetch_data is the memory output in that next cycle.
//  ld_start together with fetch_req in RUN: the fetch is accepted and returns normally next cycle.
//  Outside WR: mem_rw_en=1 and mem_addr=fetch_addr (reads are harmless and unreported).
//  wr_addr wraps 2**ADDR_W-1 -> 0; with ld_words=0 exactly 2**ADDR_W words are written.
//  Packing: LO_FIRST=1 -> {second,first}; LO_FIRST=0 -> {first,second}.
// STRUCTURE
//  imem_defs.vh: state encodings (RUN, LO, HI, WR, DONE), IMEM_DATA_W=16, byte width 8.
//  One sub-module: imem_word_packer (two byte registers, LO_FIRST ordering, clear on abort/rst).
//  Everything else (FSM, address and word counters, port mux) stays in this module.
// TESTING
//  Reset, fetch_req addr 0x05 with mem=0xBEEF -> next cycle fetch_valid=1, fetch_data=0xBEEF, mem_rw_en=1.
//  ld_start ld_words=2, bytes 34,12,78,56 -> writes 0x1234@0, 0x5678@1; ld_done pulses once; fetch_stall 1 -> 0.
//  ld_start with fetch_req addr 0x10 in the same cycle -> fetch_valid next cycle; fetch_stall=1 from the following cycle.
//  ld_abort after a single byte -> no write, state RUN, no ld_done; a new ld_start writes from address 0.
//  ld_words=0, 512 bytes -> 256 writes at addr 0..255, no write at wrap; rst asserted in HI -> no write, RUN.
//  Random ld_valid gaps with LO_FIRST=0, bytes AB,CD -> 0xABCD@0; write and read never occur in the same cycle.

Source files
------------

// File: rtl/imem_load_arbiter_pkg.sv
// Shared types and constants for the instruction-memory load arbiter.
package imem_load_arbiter_pkg;

  localparam int DATA_W = 16;
  localparam int BYTE_W = 8;

  // Loader sequencing states. RUN is the only state where fetch is served.
  typedef enum logic [2:0] {
    ST_RUN  = 3'd0,
    ST_LO   = 3'd1,
    ST_HI   = 3'd2,
    ST_WR   = 3'd3,
    ST_DONE = 3'd4
  } ld_state_e;

  // Combine the two loader bytes into a memory word.
  // When lo_first is set, the byte that arrived first goes into the low half.
  function automatic logic [DATA_W-1:0] pack_bytes(input logic [BYTE_W-1:0] first,
                                                   input logic [BYTE_W-1:0] second,
                                                   input bit lo_first);
    return lo_first ? {second, first} : {first, second};
  endfunction

endpackage

// File: rtl/imem_load_arbiter_if.sv
// Fetch, loader and memory-port signals of the load arbiter.
interface imem_load_arbiter_if #(
  parameter int ADDR_W = 8
);
  import imem_load_arbiter_pkg::*;

  logic              fetch_req;
  logic [ADDR_W-1:0] fetch_addr;
  logic              fetch_stall;
  logic              fetch_valid;
  logic [DATA_W-1:0] fetch_data;

  logic              ld_start;
  logic [ADDR_W:0]   ld_words;
  logic              ld_abort;
  logic              ld_valid;
  logic [BYTE_W-1:0] ld_byte;
  logic              ld_ready;
  logic              ld_busy;
  logic              ld_done;

  logic              mem_rw_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  // Arbiter side.
  modport slave (
    input  fetch_req, fetch_addr, ld_start, ld_words, ld_abort, ld_valid, ld_byte, mem_rdata,
    output fetch_stall, fetch_valid, fetch_data, ld_ready, ld_busy, ld_done,
           mem_rw_en, mem_addr, mem_wdata
  );

  // CPU / loader / memory side.
  modport master (
    output fetch_req, fetch_addr, ld_start, ld_words, ld_abort, ld_valid, ld_byte, mem_rdata,
    input  fetch_stall, fetch_valid, fetch_data, ld_ready, ld_busy, ld_done,
           mem_rw_en, mem_addr, mem_wdata
  );

endinterface

// File: rtl/imem_word_packer.sv
// Holds the two bytes of the word being loaded and presents them packed.
module imem_word_packer
  import imem_load_arbiter_pkg::*;
#(
  parameter bit LO_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              cap_first,
  input  logic              cap_second,
  input  logic [BYTE_W-1:0] byte_in,
  output logic [DATA_W-1:0] word
);

  logic [BYTE_W-1:0] first_reg;
  logic [BYTE_W-1:0] second_reg;

  // Capture each byte of the pair; an abandoned load leaves nothing behind.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      first_reg  <= '0;
      second_reg <= '0;
    end else begin
      if (cap_first)  first_reg  <= byte_in;
      if (cap_second) second_reg <= byte_in;
    end
  end

  assign word = pack_bytes(first_reg, second_reg, LO_FIRST);

endmodule

// File: rtl/imem_load_arbiter.sv
// Sole owner of the instruction memory port: serves CPU fetches, and while a
// program load is running stalls fetch and writes loader byte pairs as words
// at incrementing addresses from 0.
module imem_load_arbiter
  import imem_load_arbiter_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter bit LO_FIRST = 1'b1
) (
  input logic                clk,
  input logic                rst,
  imem_load_arbiter_if.slave bus
);

  ld_state_e         state_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [ADDR_W:0]   word_cnt_reg;
  logic [ADDR_W:0]   len_reg;
  logic              fetch_valid_reg;

  logic              in_pair;
  logic              abort_pair;
  logic              cap_first;
  logic              cap_second;
  logic [ADDR_W:0]   cnt_next;
  logic              last_word;
  logic              wr_cycle;
  logic [DATA_W-1:0] packed_word;

  assign in_pair    = (state_reg == ST_LO) || (state_reg == ST_HI);
  assign abort_pair = in_pair && bus.ld_abort;
  // Abort wins over a byte offered in the same cycle.
  assign cap_first  = (state_reg == ST_LO) && bus.ld_valid && !bus.ld_abort;
  assign cap_second = (state_reg == ST_HI) && bus.ld_valid && !bus.ld_abort;

  // A word count of zero stands for a full memory; the counter then
  // reaches 2**ADDR_W exactly when the last word is being written.
  assign cnt_next  = word_cnt_reg + 1'b1;
  assign last_word = (len_reg == '0) ? cnt_next[ADDR_W] : (cnt_next == len_reg);

  imem_word_packer #(
    .LO_FIRST(LO_FIRST)
  ) u_packer (
    .clk       (clk),
    .rst       (rst),
    .clear     (abort_pair),
    .cap_first (cap_first),
    .cap_second(cap_second),
    .byte_in   (bus.ld_byte),
    .word      (packed_word)
  );

  // Load sequencing, write address/count and fetch acknowledge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg       <= ST_RUN;
      wr_addr_reg     <= '0;
      word_cnt_reg    <= '0;
      len_reg         <= '0;
      fetch_valid_reg <= 1'b0;
    end else begin
      fetch_valid_reg <= bus.fetch_req && (state_reg == ST_RUN);
      case (state_reg)
        ST_RUN: begin
          if (bus.ld_start) begin
            len_reg      <= bus.ld_words;
            wr_addr_reg  <= '0;
            word_cnt_reg <= '0;
            state_reg    <= ST_LO;
          end
        end
        ST_LO: begin
          if (bus.ld_abort)      state_reg <= ST_RUN;
          else if (bus.ld_valid) state_reg <= ST_HI;
        end
        ST_HI: begin
          if (bus.ld_abort)      state_reg <= ST_RUN;
          else if (bus.ld_valid) state_reg <= ST_WR;
        end
        ST_WR: begin
          wr_addr_reg  <= wr_addr_reg + 1'b1;
          word_cnt_reg <= cnt_next;
          state_reg    <= last_word ? ST_DONE : ST_LO;
        end
        ST_DONE: state_reg <= ST_RUN;
        default: state_reg <= ST_RUN;
      endcase
    end
  end

  // A reset cycle must never write, even if it lands in WR.
  assign wr_cycle = (state_reg == ST_WR) && !rst;

  assign bus.mem_rw_en   = !wr_cycle;
  assign bus.mem_addr    = wr_cycle ? wr_addr_reg : bus.fetch_addr;
  assign bus.mem_wdata   = packed_word;

  assign bus.fetch_stall = (state_reg != ST_RUN);
  assign bus.fetch_valid = fetch_valid_reg;
  assign bus.fetch_data  = bus.mem_rdata;

  assign bus.ld_ready    = in_pair;
  assign bus.ld_busy     = (state_reg != ST_RUN);
  assign bus.ld_done     = (state_reg == ST_DONE) && !rst;

endmodule

// File: tb/tb_imem_load_arbiter.sv
// Directed bench: two arbiters (low-byte-first and high-byte-first) each
// driving a 256x16 memory model with registered read.
module tb_imem_load_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_load_arbiter_if #(.ADDR_W(8)) a_if ();
  imem_load_arbiter_if #(.ADDR_W(8)) b_if ();

  imem_load_arbiter #(.ADDR_W(8), .LO_FIRST(1'b1)) dut_a (.clk(clk), .rst(rst), .bus(a_if.slave));
  imem_load_arbiter #(.ADDR_W(8), .LO_FIRST(1'b0)) dut_b (.clk(clk), .rst(rst), .bus(b_if.slave));

  // Memory models with a back-door poke port for preloading.
  logic        poke_en = 1'b0;
  logic [7:0]  poke_addr = '0;
  logic [15:0] poke_data = '0;
  logic [15:0] mem_a [0:255];
  logic [15:0] mem_b [0:255];
  logic [15:0] rdata_a, rdata_b;

  always @(posedge clk) begin
    if (poke_en) mem_a[poke_addr] <= poke_data;
    else if (!a_if.mem_rw_en) mem_a[a_if.mem_addr] <= a_if.mem_wdata;
    rdata_a <= mem_a[a_if.mem_addr];
    if (!b_if.mem_rw_en) mem_b[b_if.mem_addr] <= b_if.mem_wdata;
    rdata_b <= mem_b[b_if.mem_addr];
  end
  assign a_if.mem_rdata = rdata_a;
  assign b_if.mem_rdata = rdata_b;

  // Write log, done counters and write-during-fetch detector.
  logic [7:0]  wa_addr_q[$];
  logic [15:0] wa_data_q[$];
  logic [7:0]  wb_addr_q[$];
  logic [15:0] wb_data_q[$];
  int done_a = 0;
  int done_b = 0;
  int overlap_err = 0;

  always @(posedge clk) begin
    if (!a_if.mem_rw_en) begin
      wa_addr_q.push_back(a_if.mem_addr);
      wa_data_q.push_back(a_if.mem_wdata);
      if (!a_if.fetch_stall) overlap_err++;
    end
    if (!b_if.mem_rw_en) begin
      wb_addr_q.push_back(b_if.mem_addr);
      wb_data_q.push_back(b_if.mem_wdata);
      if (!b_if.fetch_stall) overlap_err++;
    end
    if (a_if.ld_done) done_a++;
    if (b_if.ld_done) done_b++;
  end

  int vectors = 0;
  int miscompares = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer one byte to arbiter A (sel=0) or B (sel=1) until it is accepted.
  task automatic send_byte(input bit sel, input logic [7:0] b);
    int n = 0;
    if (sel) begin b_if.ld_valid = 1'b1; b_if.ld_byte = b; end
    else     begin a_if.ld_valid = 1'b1; a_if.ld_byte = b; end
    while (!(sel ? b_if.ld_ready : a_if.ld_ready) && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) check_val("ready_timeout", 32'd0, 32'd1);
    tick();
    if (sel) b_if.ld_valid = 1'b0;
    else     a_if.ld_valid = 1'b0;
  endtask

  task automatic start_load(input bit sel, input logic [8:0] words);
    if (sel) begin b_if.ld_start = 1'b1; b_if.ld_words = words; end
    else     begin a_if.ld_start = 1'b1; a_if.ld_words = words; end
    tick();
    a_if.ld_start = 1'b0;
    b_if.ld_start = 1'b0;
  endtask

  // Bounded wait for ld_done on arbiter A or B.
  task automatic wait_done(input bit sel, input string tag);
    int n = 0;
    while (!(sel ? b_if.ld_done : a_if.ld_done) && n < 20) begin
      tick();
      n++;
    end
    check_val(tag, 32'(sel ? b_if.ld_done : a_if.ld_done), 32'd1);
    tick();
  endtask

  int base;
  int errs;

  initial begin
    a_if.fetch_req = 0; a_if.fetch_addr = '0; a_if.ld_start = 0; a_if.ld_words = '0;
    a_if.ld_abort = 0; a_if.ld_valid = 0; a_if.ld_byte = '0;
    b_if.fetch_req = 0; b_if.fetch_addr = '0; b_if.ld_start = 0; b_if.ld_words = '0;
    b_if.ld_abort = 0; b_if.ld_valid = 0; b_if.ld_byte = '0;

    // Reset state
    tick(); tick();
    check_val("rst_fetch_valid", 32'(a_if.fetch_valid), 32'd0);
    check_val("rst_ld_done", 32'(a_if.ld_done), 32'd0);
    check_val("rst_rw_en", 32'(a_if.mem_rw_en), 32'd1);
    check_val("rst_stall", 32'(a_if.fetch_stall), 32'd0);
    check_val("rst_busy", 32'(a_if.ld_busy), 32'd0);
    rst = 1'b0;

    // Preload and plain fetch
    poke_en = 1; poke_addr = 8'h05; poke_data = 16'hBEEF; tick();
    poke_addr = 8'h10; poke_data = 16'h0A0A; tick();
    poke_en = 0;
    a_if.fetch_req = 1; a_if.fetch_addr = 8'h05;
    tick();
    a_if.fetch_req = 0;
    check_val("fetch_valid", 32'(a_if.fetch_valid), 32'd1);
    check_val("fetch_data", 32'(a_if.fetch_data), 32'h0000BEEF);
    check_val("fetch_rw_en", 32'(a_if.mem_rw_en), 32'd1);
    tick();
    check_val("fetch_valid_drop", 32'(a_if.fetch_valid), 32'd0);

    // Two-word load, low byte first
    base = wa_addr_q.size();
    start_load(0, 9'd2);
    check_val("load_stall", 32'(a_if.fetch_stall), 32'd1);
    check_val("load_ready", 32'(a_if.ld_ready), 32'd1);
    send_byte(0, 8'h34);
    send_byte(0, 8'h12);
    check_val("wr0_rw_en", 32'(a_if.mem_rw_en), 32'd0);
    check_val("wr0_addr", 32'(a_if.mem_addr), 32'd0);
    check_val("wr0_data", 32'(a_if.mem_wdata), 32'h00001234);
    check_val("wr0_ready", 32'(a_if.ld_ready), 32'd0);
    send_byte(0, 8'h78);
    send_byte(0, 8'h56);
    check_val("wr1_addr", 32'(a_if.mem_addr), 32'd1);
    check_val("wr1_data", 32'(a_if.mem_wdata), 32'h00005678);
    tick();
    check_val("done_pulse", 32'(a_if.ld_done), 32'd1);
    tick();
    check_val("done_clear", 32'(a_if.ld_done), 32'd0);
    check_val("stall_clear", 32'(a_if.fetch_stall), 32'd0);
    check_val("load2_count", 32'(wa_addr_q.size() - base), 32'd2);
    check_val("load2_w0", {8'(wa_addr_q[base]), 8'h00, wa_data_q[base]}, 32'h00001234);
    check_val("load2_w1", {8'(wa_addr_q[base+1]), 8'h00, wa_data_q[base+1]}, 32'h01005678);
    check_val("load2_dones", 32'(done_a), 32'd1);

    // ld_start together with fetch_req, then abort with a same-cycle byte
    base = wa_addr_q.size();
    a_if.fetch_req = 1; a_if.fetch_addr = 8'h10;
    start_load(0, 9'd3);
    a_if.fetch_req = 0;
    check_val("start_fetch_valid", 32'(a_if.fetch_valid), 32'd1);
    check_val("start_fetch_data", 32'(a_if.fetch_data), 32'h00000A0A);
    check_val("start_fetch_stall", 32'(a_if.fetch_stall), 32'd1);
    send_byte(0, 8'h99);
    a_if.ld_abort = 1; a_if.ld_valid = 1; a_if.ld_byte = 8'h88;
    tick();
    a_if.ld_abort = 0; a_if.ld_valid = 0;
    check_val("abort_busy", 32'(a_if.ld_busy), 32'd0);
    tick(); tick();
    check_val("abort_no_write", 32'(wa_addr_q.size() - base), 32'd0);
    check_val("abort_no_done", 32'(done_a), 32'd1);

    // Fresh load after abort restarts at address 0
    start_load(0, 9'd1);
    send_byte(0, 8'h11);
    send_byte(0, 8'h22);
    wait_done(0, "reload_done");
    check_val("reload_w0", {8'(wa_addr_q[base]), 8'h00, wa_data_q[base]}, 32'h00002211);

    // Full-memory load with ld_words = 0
    base = wa_addr_q.size();
    start_load(0, 9'd0);
    for (int i = 0; i < 256; i++) begin
      logic [7:0] lo;
      lo = 8'(i);
      send_byte(0, lo);
      send_byte(0, ~lo);
    end
    wait_done(0, "fill_done");
    tick(); tick();
    check_val("fill_count", 32'(wa_addr_q.size() - base), 32'd256);
    errs = 0;
    for (int i = 0; i < 256; i++) begin
      logic [7:0] lo;
      lo = 8'(i);
      if (wa_addr_q[base+i] !== lo || wa_data_q[base+i] !== {~lo, lo}) errs++;
    end
    check_val("fill_contents", 32'(errs), 32'd0);
    check_val("fill_dones", 32'(done_a), 32'd3);

    // Reset in HI: no write, back to RUN
    base = wa_addr_q.size();
    start_load(0, 9'd1);
    send_byte(0, 8'h55);
    rst = 1;
    tick();
    check_val("rst_hi_busy", 32'(a_if.ld_busy), 32'd0);
    rst = 0;
    tick();
    check_val("rst_hi_no_write", 32'(wa_addr_q.size() - base), 32'd0);

    // Reset while in WR: the write is suppressed
    start_load(0, 9'd1);
    send_byte(0, 8'h66);
    send_byte(0, 8'h77);
    rst = 1;
    #1;
    check_val("rst_wr_rw_en", 32'(a_if.mem_rw_en), 32'd1);
    tick();
    rst = 0;
    tick();
    check_val("rst_wr_no_write", 32'(wa_addr_q.size() - base), 32'd0);
    check_val("rst_wr_busy", 32'(a_if.ld_busy), 32'd0);
    check_val("rst_no_done", 32'(done_a), 32'd3);

    // High-byte-first arbiter with random gaps between bytes
    start_load(1, 9'd1);
    repeat ($urandom_range(0, 3)) tick();
    send_byte(1, 8'hAB);
    repeat ($urandom_range(0, 3)) tick();
    send_byte(1, 8'hCD);
    wait_done(1, "hifirst_done");
    check_val("hifirst_count", 32'(wb_addr_q.size()), 32'd1);
    check_val("hifirst_w0", {8'(wb_addr_q[0]), 8'h00, wb_data_q[0]}, 32'h0000ABCD);
    check_val("hifirst_dones", 32'(done_b), 32'd1);

    check_val("no_rw_overlap", 32'(overlap_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
